ysyx_22050019_mul_ctrl: RTL and testbench



---
 rtl/ysyx_22050019_mdu_pkg.sv | 30 +++
 rtl/ysyx_22050019_mul_decode.sv | 27 ++
 rtl/ysyx_22050019_mul_ctrl.sv | 152 +++++++++++++++
 tb/tb_ysyx_22050019_mul_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_mdu_pkg.sv
// Shared MDU definitions: multiplier one-hot op types, RV64M funct3 codes and
// the multiply controller state encoding.
package ysyx_22050019_mdu_pkg;

   // One-hot operation select presented to the Booth multiplier
   localparam logic [4:0] MultNone   = 5'b00000;
   localparam logic [4:0] MultMul    = 5'b00001;
   localparam logic [4:0] MultMulh   = 5'b00010;
   localparam logic [4:0] MultMulhsu = 5'b00100;
   localparam logic [4:0] MultMulhu  = 5'b01000;
   localparam logic [4:0] MultMulw   = 5'b10000;

   // RV64M multiply-class funct3 codes
   localparam logic [2:0] F3Mul    = 3'b000;
   localparam logic [2:0] F3Mulh   = 3'b001;
   localparam logic [2:0] F3Mulhsu = 3'b010;
   localparam logic [2:0] F3Mulhu  = 3'b011;

   // Width of the launch-to-result cycle counter
   localparam int unsigned CntW = 7;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLaunch = 3'd1,
      StWait   = 3'd2,
      StDrain  = 3'd3,
      StDone   = 3'd4
   } mul_ctrl_state_e;

endpackage

// File: rtl/ysyx_22050019_mul_decode.sv
// Combinational decode of funct3 / OP-32 form into the multiplier one-hot type.
// Unsupported combinations map to MultNone; the multiplier then returns 0.
module ysyx_22050019_mul_decode
   import ysyx_22050019_mdu_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_is_word,
   output logic [4:0] o_mult_type
);

   // Map funct3 and word form onto a single one-hot operation
   always_comb begin
      o_mult_type = MultNone;
      if (i_is_word) begin
         if (i_funct3 == F3Mul) o_mult_type = MultMulw;
      end else begin
         case (i_funct3)
            F3Mul:    o_mult_type = MultMul;
            F3Mulh:   o_mult_type = MultMulh;
            F3Mulhsu: o_mult_type = MultMulhsu;
            F3Mulhu:  o_mult_type = MultMulhu;
            default:  o_mult_type = MultNone;
         endcase
      end
   end

endmodule

// File: rtl/ysyx_22050019_mul_ctrl.sv
// Sequencing controller between EX and the shared multi-cycle Booth multiplier.
// Captures operands, launches the multiplier, stalls the front end while it runs,
// holds the product for write-back and drains the multiplier on a flush.
module ysyx_22050019_mul_ctrl
   import ysyx_22050019_mdu_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned TAG_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_ex_valid,
   input  logic [2:0]        i_ex_funct3,
   input  logic              i_ex_is_word,
   input  logic [XLEN-1:0]   i_ex_src1,
   input  logic [XLEN-1:0]   i_ex_src2,
   input  logic [TAG_W-1:0]  i_ex_tag,
   input  logic              i_flush,
   input  logic              i_wb_ready,
   output logic              o_ctrl_stall,
   output logic              o_wb_valid,
   output logic [XLEN-1:0]   o_wb_data,
   output logic [TAG_W-1:0]  o_wb_tag,
   output logic [CntW-1:0]   o_mul_cycles,
   output logic              o_mult_valid,
   output logic [4:0]        o_mult_type,
   output logic [XLEN-1:0]   o_mult_a,
   output logic [XLEN-1:0]   o_mult_b,
   output logic              o_result_ready,
   input  logic [XLEN-1:0]   i_mult_out,
   input  logic              i_mult_busy,
   input  logic              i_result_ok
);

   mul_ctrl_state_e  r_state;
   logic             r_mult_valid;
   logic             r_wb_valid;
   logic [XLEN-1:0]  r_wb_data;
   logic [TAG_W-1:0] r_wb_tag;
   logic [TAG_W-1:0] r_tag;
   logic [4:0]       r_mult_type;
   logic [XLEN-1:0]  r_mult_a;
   logic [XLEN-1:0]  r_mult_b;
   logic [CntW-1:0]  r_cnt;
   logic [CntW-1:0]  r_mul_cycles;

   logic [4:0]       w_dec_type;
   logic             w_accept;
   logic [CntW-1:0]  w_cnt_inc;
   logic             w_stall;

   ysyx_22050019_mul_decode u_decode (
      .i_funct3    (i_ex_funct3),
      .i_is_word   (i_ex_is_word),
      .o_mult_type (w_dec_type)
   );

   // A busy multiplier blocks a new launch; the stall term below keeps EX frozen
   assign w_accept  = (r_state == StIdle) & i_ex_valid & ~i_flush & ~i_mult_busy;
   assign w_cnt_inc = (r_cnt == {CntW{1'b1}}) ? r_cnt : r_cnt + 1'b1;

   // Controller FSM with registered request, result and statistics outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_mult_valid <= 1'b0;
         r_wb_valid   <= 1'b0;
         r_wb_data    <= '0;
         r_wb_tag     <= '0;
         r_tag        <= '0;
         r_mult_type  <= '0;
         r_mult_a     <= '0;
         r_mult_b     <= '0;
         r_cnt        <= '0;
         r_mul_cycles <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_mult_type  <= w_dec_type;
                  r_mult_a     <= i_ex_src1;
                  r_mult_b     <= i_ex_src2;
                  r_tag        <= i_ex_tag;
                  r_mult_valid <= 1'b1;
                  r_state      <= StLaunch;
               end
            end
            StLaunch: begin
               r_mult_valid <= 1'b0;
               r_cnt        <= '0;
               r_state      <= i_flush ? StDrain : StWait;
            end
            StWait: begin
               r_cnt <= w_cnt_inc;
               if (i_result_ok) begin
                  if (i_flush) begin
                     r_state <= StIdle;
                  end else begin
                     r_wb_data    <= i_mult_out;
                     r_wb_tag     <= r_tag;
                     r_mul_cycles <= w_cnt_inc;
                     r_wb_valid   <= 1'b1;
                     r_state      <= StDone;
                  end
               end else if (i_flush) begin
                  r_state <= StDrain;
               end
            end
            StDrain: begin
               if (i_result_ok) r_state <= StIdle;
            end
            StDone: begin
               if (i_flush || i_wb_ready) begin
                  r_wb_valid <= 1'b0;
                  r_state    <= StIdle;
               end
            end
            default: begin
               r_mult_valid <= 1'b0;
               r_wb_valid   <= 1'b0;
               r_state      <= StIdle;
            end
         endcase
      end
   end

   // Front-end stall: hold EX while an op is accepted, in flight or unretired
   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         StIdle:   w_stall = i_ex_valid & ~i_flush;
         StLaunch: w_stall = 1'b1;
         StWait:   w_stall = 1'b1;
         StDrain:  w_stall = i_ex_valid;
         StDone:   w_stall = ~i_wb_ready & ~i_flush;
         default:  w_stall = 1'b0;
      endcase
   end

   assign o_ctrl_stall   = w_stall;
   // A flush in DONE must suppress the write-back even if wb_ready is also high
   assign o_wb_valid     = r_wb_valid & ~i_flush;
   assign o_wb_data      = r_wb_data;
   assign o_wb_tag       = r_wb_tag;
   assign o_mul_cycles   = r_mul_cycles;
   assign o_mult_valid   = r_mult_valid;
   assign o_mult_type    = r_mult_type;
   assign o_mult_a       = r_mult_a;
   assign o_mult_b       = r_mult_b;
   assign o_result_ready = i_result_ok & ((r_state == StWait) | (r_state == StDrain));

endmodule

// File: tb/tb_ysyx_22050019_mul_ctrl.sv
// Bench for the multiply controller: a behavioural multiplier answers launches,
// expected write-backs go through a scoreboard queue.
module tb_ysyx_22050019_mul_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [2:0]  ex_funct3;
   logic        ex_is_word;
   logic [63:0] ex_src1;
   logic [63:0] ex_src2;
   logic [4:0]  ex_tag;
   logic        flush;
   logic        wb_ready;
   logic        ctrl_stall;
   logic        wb_valid;
   logic [63:0] wb_data;
   logic [4:0]  wb_tag;
   logic [6:0]  mul_cycles;
   logic        mult_valid;
   logic [4:0]  mult_type;
   logic [63:0] mult_a;
   logic [63:0] mult_b;
   logic        result_ready;
   logic [63:0] mult_out;
   logic        mult_busy;
   logic        result_ok;

   int n_total;
   int n_bad;

   typedef struct packed {
      logic [63:0] data;
      logic [4:0]  tag;
   } exp_t;
   exp_t sb[$];

   ysyx_22050019_mul_ctrl #(.XLEN(64), .TAG_W(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_ex_valid     (ex_valid),
      .i_ex_funct3    (ex_funct3),
      .i_ex_is_word   (ex_is_word),
      .i_ex_src1      (ex_src1),
      .i_ex_src2      (ex_src2),
      .i_ex_tag       (ex_tag),
      .i_flush        (flush),
      .i_wb_ready     (wb_ready),
      .o_ctrl_stall   (ctrl_stall),
      .o_wb_valid     (wb_valid),
      .o_wb_data      (wb_data),
      .o_wb_tag       (wb_tag),
      .o_mul_cycles   (mul_cycles),
      .o_mult_valid   (mult_valid),
      .o_mult_type    (mult_type),
      .o_mult_a       (mult_a),
      .o_mult_b       (mult_b),
      .o_result_ready (result_ready),
      .i_mult_out     (mult_out),
      .i_mult_busy    (mult_busy),
      .i_result_ok    (result_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier: latency 1 for a zero multiplier, g_lat otherwise
   logic        m_busy;
   int unsigned m_cnt;
   logic [63:0] m_res;
   logic        busy_force;
   int unsigned g_lat;

   function automatic logic [63:0] ref_mul(input logic [4:0] t, input logic [63:0] a,
                                           input logic [63:0] b);
      logic [127:0] pa, pb, p;
      logic [63:0]  lo;
      logic [31:0]  w;
      pa = '0; pb = '0; p = '0; lo = '0; w = '0;
      case (t)
         5'b00001: begin lo = a * b; return lo; end
         5'b00010: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; end
         5'b00100: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b}; end
         5'b01000: begin pa = {64'd0, a}; pb = {64'd0, b}; end
         5'b10000: begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
         default:  return 64'd0;
      endcase
      p = pa * pb;
      return p[127:64];
   endfunction

   assign result_ok = m_busy && (m_cnt == 1);
   assign mult_busy = m_busy | busy_force;
   assign mult_out  = m_res;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
         m_res  <= '0;
      end else if (m_busy) begin
         if (m_cnt == 1) m_busy <= 1'b0;
         m_cnt <= m_cnt - 1;
      end else if (mult_valid) begin
         m_busy <= 1'b1;
         m_cnt  <= (mult_b == 64'd0) ? 1 : g_lat;
         m_res  <= ref_mul(mult_type, mult_a, mult_b);
      end
   end

   // Wait (bounded) for wb_valid, recording any relaunch or stall gap on the way
   task automatic wait_done(output int cyc, output bit mv, output bit nostall);
      cyc = 0; mv = 0; nostall = 0;
      do begin
         @(negedge clk); #1;
         cyc++;
         if (mult_valid) mv = 1;
         if (!wb_valid && !ctrl_stall) nostall = 1;
      end while (!wb_valid && cyc < 100);
   endtask

   task automatic drive_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] tag);
      ex_valid = 1'b1; ex_funct3 = f3; ex_is_word = w;
      ex_src1 = a; ex_src2 = b; ex_tag = tag;
   endtask

   task automatic test_reset;
      logic [3:0]   ctl;
      logic [208:0] dat;
      rst_n = 1'b0; ex_valid = 0; ex_funct3 = 0; ex_is_word = 0; ex_src1 = 0; ex_src2 = 0;
      ex_tag = 0; flush = 0; wb_ready = 0; busy_force = 0; g_lat = 8;
      repeat (3) @(negedge clk);
      #1;
      ctl = {mult_valid, result_ready, wb_valid, ctrl_stall};
      dat = {wb_data, wb_tag, mult_a, mult_b, mult_type, mul_cycles};
      n_total++;
      if (ctl !== 4'b0) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000", ctl); end
      n_total++;
      if (dat !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", dat); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   typedef struct packed {
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  tag;
      logic [4:0]  typ;
      logic [63:0] res;
      logic [6:0]  cyc;
   } op_t;

   task automatic test_arith;
      op_t ops[10];
      exp_t e;
      int cyc; bit mv, ns;
      ops[0] = '{3'b000, 1'b0, 64'd3, 64'd5, 5'd7, 5'b00001, 64'd15, 7'd8};
      ops[1] = '{3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1,
                 5'b00010, 64'd0, 7'd8};
      ops[2] = '{3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 5'b01000, 64'd1, 7'd8};
      ops[3] = '{3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 5'b00100,
                 64'hFFFF_FFFF_FFFF_FFFF, 7'd8};
      ops[4] = '{3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd4, 5'b10000,
                 64'hFFFF_FFFF_FFFF_FFFE, 7'd8};
      ops[5] = '{3'b000, 1'b0, 64'd12345, 64'd0, 5'd5, 5'b00001, 64'd0, 7'd1};
      ops[6] = '{3'b000, 1'b0, 64'h1_0000_0001, 64'd3, 5'd6, 5'b00001, 64'h3_0000_0003, 7'd8};
      ops[7] = '{3'b100, 1'b0, 64'd6, 64'd7, 5'd8, 5'b00000, 64'd0, 7'd8};
      ops[8] = '{3'b001, 1'b1, 64'd9, 64'd9, 5'd9, 5'b00000, 64'd0, 7'd8};
      ops[9] = '{3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 5'd10, 5'b00010,
                 64'hFFFF_FFFF_FFFF_FFFF, 7'd8};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive_op(ops[i].f3, ops[i].w, ops[i].a, ops[i].b, ops[i].tag);
         sb.push_back('{data: ops[i].res, tag: ops[i].tag});
         #1;
         n_total++;
         if (ctrl_stall !== 1'b1) begin
            n_bad++; $display("FAIL accept_stall op%0d: got %b want 1", i, ctrl_stall);
         end
         @(negedge clk);
         ex_valid = 1'b0;
         #1;
         n_total++;
         if ({mult_valid, mult_type, mult_a, mult_b} !== {1'b1, ops[i].typ, ops[i].a, ops[i].b})
         begin
            n_bad++;
            $display("FAIL launch op%0d: got v=%b t=%b a=%h b=%h want v=1 t=%b a=%h b=%h", i,
                     mult_valid, mult_type, mult_a, mult_b, ops[i].typ, ops[i].a, ops[i].b);
         end
         wait_done(cyc, mv, ns);
         e = sb.pop_front();
         n_total++;
         if ({wb_valid, ctrl_stall} !== 2'b11) begin
            n_bad++; $display("FAIL done_flags op%0d: got %b want 11", i, {wb_valid, ctrl_stall});
         end
         n_total++;
         if ({wb_data, wb_tag} !== {e.data, e.tag}) begin
            n_bad++;
            $display("FAIL wb_result op%0d: got %h/%0d want %h/%0d", i, wb_data, wb_tag,
                     e.data, e.tag);
         end
         n_total++;
         if (mul_cycles !== ops[i].cyc) begin
            n_bad++; $display("FAIL mul_cycles op%0d: got %0d want %0d", i, mul_cycles, ops[i].cyc);
         end
         n_total++;
         if (cyc !== int'(ops[i].cyc) + 1) begin
            n_bad++; $display("FAIL latency op%0d: got %0d want %0d", i, cyc, ops[i].cyc + 1);
         end
         n_total++;
         if ({mv, ns} !== 2'b00) begin
            n_bad++; $display("FAIL inflight op%0d: relaunch=%b stall_gap=%b want 0/0", i, mv, ns);
         end
         wb_ready = 1'b1;
         #1;
         n_total++;
         if (ctrl_stall !== 1'b0) begin
            n_bad++; $display("FAIL release_stall op%0d: got %b want 0", i, ctrl_stall);
         end
         @(negedge clk);
         wb_ready = 1'b0;
         #1;
         n_total++;
         if (wb_valid !== 1'b0) begin
            n_bad++; $display("FAIL retire op%0d: wb_valid got %b want 0", i, wb_valid);
         end
      end
   endtask

   task automatic test_flush_drain;
      exp_t e;
      int cyc, rr; bit mv, ns, wbv, nost, got;
      @(negedge clk);
      drive_op(3'b000, 1'b0, 64'd10, 64'd11, 5'd20);
      @(negedge clk);
      ex_valid = 1'b0;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      drive_op(3'b000, 1'b0, 64'd4, 64'd9, 5'd21);
      sb.push_back('{data: 64'd36, tag: 5'd21});
      rr = 0; wbv = 0; nost = 0; got = 0;
      for (int k = 0; k < 60; k++) begin
         #1;
         if (mult_valid) begin got = 1; break; end
         if (result_ready) rr++;
         if (wb_valid) wbv = 1;
         if (!ctrl_stall) nost = 1;
         @(negedge clk);
      end
      ex_valid = 1'b0;
      n_total++;
      if (got !== 1'b1 || mult_a !== 64'd4) begin
         n_bad++; $display("FAIL drain_relaunch: got launch=%b a=%h want 1/4", got, mult_a);
      end
      n_total++;
      if (rr !== 1) begin n_bad++; $display("FAIL drain_ready_pulses: got %0d want 1", rr); end
      n_total++;
      if ({wbv, nost} !== 2'b00) begin
         n_bad++; $display("FAIL drain_flags: wb_valid=%b stall_gap=%b want 0/0", wbv, nost);
      end
      wait_done(cyc, mv, ns);
      e = sb.pop_front();
      n_total++;
      if ({wb_valid, wb_data, wb_tag} !== {1'b1, e.data, e.tag}) begin
         n_bad++;
         $display("FAIL drain_next_result: got %b %h/%0d want 1 %h/%0d", wb_valid, wb_data,
                  wb_tag, e.data, e.tag);
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
   endtask

   task automatic test_wb_hold;
      exp_t e;
      int cyc; bit mv, ns;
      @(negedge clk);
      drive_op(3'b000, 1'b0, 64'd6, 64'd7, 5'd12);
      sb.push_back('{data: 64'd42, tag: 5'd12});
      @(negedge clk);
      ex_valid = 1'b0;
      wait_done(cyc, mv, ns);
      e = sb.pop_front();
      for (int k = 0; k < 4; k++) begin
         n_total++;
         if ({wb_valid, ctrl_stall, wb_data, wb_tag} !== {2'b11, e.data, e.tag}) begin
            n_bad++;
            $display("FAIL hold cyc%0d: got v=%b s=%b %h/%0d want 1 1 %h/%0d", k, wb_valid,
                     ctrl_stall, wb_data, wb_tag, e.data, e.tag);
         end
         @(negedge clk); #1;
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
   endtask

   task automatic test_flush_done;
      int cyc, seen; bit mv, ns;
      @(negedge clk);
      drive_op(3'b000, 1'b0, 64'd2, 64'd2, 5'd13);
      @(negedge clk);
      ex_valid = 1'b0;
      wait_done(cyc, mv, ns);
      flush = 1'b1;
      wb_ready = 1'b1;
      #1;
      n_total++;
      if ({wb_valid, ctrl_stall} !== 2'b00) begin
         n_bad++; $display("FAIL flush_done: got v=%b s=%b want 0 0", wb_valid, ctrl_stall);
      end
      @(negedge clk);
      flush = 1'b0;
      wb_ready = 1'b0;
      seen = 0;
      repeat (5) begin
         #1;
         if (wb_valid) seen++;
         @(negedge clk);
      end
      n_total++;
      if (seen !== 0) begin n_bad++; $display("FAIL flush_done_after: wb_valid %0d want 0", seen); end
   endtask

   task automatic test_reset_mid;
      logic [212:0] snap;
      int seen;
      @(negedge clk);
      drive_op(3'b000, 1'b0, 64'd8, 64'd8, 5'd14);
      @(negedge clk);
      ex_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk); #1;
      snap = {mult_valid, result_ready, wb_valid, ctrl_stall, wb_data, wb_tag, mult_a, mult_b,
              mult_type, mul_cycles};
      n_total++;
      if (snap !== '0) begin n_bad++; $display("FAIL reset_mid: got %h want 0", snap); end
      rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk); #1;
         if (wb_valid || result_ready || mult_valid) seen++;
      end
      n_total++;
      if (seen !== 0) begin n_bad++; $display("FAIL reset_after: activity %0d want 0", seen); end
   endtask

   task automatic test_busy;
      exp_t e;
      int cyc, bad; bit mv, ns;
      busy_force = 1'b1;
      @(negedge clk);
      drive_op(3'b011, 1'b0, 64'd5, 64'd5, 5'd15);
      sb.push_back('{data: 64'd0, tag: 5'd15});
      bad = 0;
      repeat (3) begin
         #1;
         if (!ctrl_stall || mult_valid) bad++;
         @(negedge clk);
      end
      n_total++;
      if (bad !== 0) begin n_bad++; $display("FAIL busy_hold: bad cycles %0d want 0", bad); end
      busy_force = 1'b0;
      @(negedge clk);
      ex_valid = 1'b0;
      #1;
      n_total++;
      if ({mult_valid, mult_type} !== {1'b1, 5'b01000}) begin
         n_bad++; $display("FAIL busy_launch: got %b/%b want 1/01000", mult_valid, mult_type);
      end
      wait_done(cyc, mv, ns);
      e = sb.pop_front();
      n_total++;
      if ({wb_valid, wb_data, wb_tag} !== {1'b1, e.data, e.tag}) begin
         n_bad++;
         $display("FAIL busy_result: got %b %h/%0d want 1 %h/%0d", wb_valid, wb_data, wb_tag,
                  e.data, e.tag);
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
   endtask

   initial begin
      n_total = 0;
      n_bad = 0;
      test_reset();
      test_arith();
      test_flush_drain();
      test_wb_hold();
      test_flush_done();
      test_busy();
      test_reset_mid();
      n_total++;
      if (sb.size() !== 0) begin
         n_bad++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
